vregfile_sched: RTL

//  Sequences one vector instruction at a time through the banked, duplicated-read-port vector register file.

---
 rtl/vregfile_sched_pkg.sv | 22 ++
 rtl/vregfile_grp_ctr.sv | 53 +++++
 rtl/vregfile_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vregfile_sched_pkg.sv
// Shared constants for the vector regfile scheduler: state encoding, default geometry, row-address helper.
// No logic; imported by vregfile_sched and vregfile_grp_ctr.
package vregfile_sched_pkg;

   localparam int DEF_NUMBANKS      = 4;
   localparam int DEF_LOG2NUMBANKS  = 2;
   localparam int DEF_WIDTH         = 32;
   localparam int DEF_LOG2NUMVREGS  = 3;
   localparam int DEF_LOG2MAXGROUPS = 2;
   localparam int DEF_MAXVL         = DEF_NUMBANKS << DEF_LOG2MAXGROUPS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_WBONLY = 2'd2;

   // Bank row is {vreg, group}; caller truncates to the real row width.
   function automatic logic [31:0] row_addr(input logic [31:0] vreg, input logic [31:0] grp,
                                            input int log2maxgroups);
      return (vreg << log2maxgroups) | grp;
   endfunction

endpackage

// File: rtl/vregfile_grp_ctr.sv
// Group counter: tracks the current element group, its lane mask and whether it is the last group.
// Latency: mask/last/busy are combinational from the count; count advances on the clock edge.
// Backpressure: advances only when i_advance is asserted and groups remain.
module vregfile_grp_ctr
   import vregfile_sched_pkg::*;
#(
   parameter int NUMBANKS      = DEF_NUMBANKS,
   parameter int LOG2NUMBANKS  = DEF_LOG2NUMBANKS,
   parameter int LOG2MAXGROUPS = DEF_LOG2MAXGROUPS
)(
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_load,
   input  logic [LOG2NUMBANKS+LOG2MAXGROUPS:0]   i_vl,
   input  logic                                  i_advance,
   output logic [LOG2MAXGROUPS-1:0]              o_grp,
   output logic [NUMBANKS-1:0]                   o_mask,
   output logic                                  o_last,
   output logic                                  o_busy
);
   localparam int LOG2MAXVL = LOG2NUMBANKS + LOG2MAXGROUPS;

   logic [LOG2MAXGROUPS:0] r_cnt;
   logic [LOG2MAXVL:0]     r_vl;
   logic [LOG2MAXVL:0]     w_vl_rnd;
   logic [LOG2MAXGROUPS:0] w_ngroups;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_vl  <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
         r_vl  <= i_vl;
      end else if (i_advance && o_busy) begin
         r_cnt <= r_cnt + (LOG2MAXGROUPS+1)'(1);
      end
   end

   assign w_vl_rnd  = r_vl + (LOG2MAXVL+1)'(NUMBANKS - 1);
   assign w_ngroups = w_vl_rnd[LOG2MAXVL:LOG2NUMBANKS];
   assign o_grp     = r_cnt[LOG2MAXGROUPS-1:0];
   assign o_busy    = r_cnt < w_ngroups;
   assign o_last    = (r_cnt + (LOG2MAXGROUPS+1)'(1)) == w_ngroups;

   // Element index of lane k is {group, k}; lanes at or beyond vl are masked off.
   always_comb begin
      o_mask = '0;
      for (int k = 0; k < NUMBANKS; k++)
         o_mask[k] = {r_cnt, LOG2NUMBANKS'(k)} < r_vl;
   end

endmodule

// File: rtl/vregfile_sched.sv
// Vector regfile scheduler: one instruction at a time, one element group per cycle; optional stall counter under VREGFILE_SCHED_PERF_EN.
// Latency: read enables combinational on issue, out_valid/q_b one cycle later; done one cycle after the last write-back.
// Backpressure: out_valid & !out_ready freezes read enables and addresses; wb_ready drops once all groups are written.
module vregfile_sched
   import vregfile_sched_pkg::*;
#(
   parameter int NUMBANKS      = DEF_NUMBANKS,
   parameter int LOG2NUMBANKS  = DEF_LOG2NUMBANKS,
   parameter int WIDTH         = DEF_WIDTH,
   parameter int LOG2NUMVREGS  = DEF_LOG2NUMVREGS,
   parameter int LOG2MAXGROUPS = DEF_LOG2MAXGROUPS
)(
   input  logic                                                   clk,
   input  logic                                                   resetn,
   input  logic                                                   in_valid,
   output logic                                                   in_ready,
   input  logic [LOG2NUMVREGS-1:0]                                in_areg,
   input  logic [LOG2NUMVREGS-1:0]                                in_breg,
   input  logic [LOG2NUMVREGS-1:0]                                in_dreg,
   input  logic [LOG2NUMBANKS+LOG2MAXGROUPS:0]                    in_vl,
   output logic [NUMBANKS*(LOG2NUMVREGS+LOG2MAXGROUPS)-1:0]       a_reg,
   output logic [NUMBANKS*(LOG2NUMVREGS+LOG2MAXGROUPS)-1:0]       b_reg,
   output logic [NUMBANKS*(LOG2NUMVREGS+LOG2MAXGROUPS)-1:0]       c_reg,
   output logic [NUMBANKS-1:0]                                    a_en,
   output logic [NUMBANKS-1:0]                                    b_en,
   output logic [NUMBANKS-1:0]                                    c_we,
   output logic [NUMBANKS*WIDTH/8-1:0]                            c_byteen,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [NUMBANKS-1:0]                                    out_mask,
   output logic                                                   out_last,
   input  logic                                                   wb_valid,
   output logic                                                   wb_ready,
   input  logic [NUMBANKS*WIDTH/8-1:0]                            wb_byteen,
   output logic                                                   done
`ifdef VREGFILE_SCHED_PERF_EN
   ,
   output logic [31:0]                                            stall_cycles
`endif
);
   localparam int LOG2MAXVL = LOG2NUMBANKS + LOG2MAXGROUPS;
   localparam int ROWW      = LOG2NUMVREGS + LOG2MAXGROUPS;
   localparam int BPE       = WIDTH / 8;
   localparam logic [LOG2MAXVL:0] MAXVL = (LOG2MAXVL+1)'(NUMBANKS << LOG2MAXGROUPS);

   logic [1:0]              r_state;
   logic [LOG2NUMVREGS-1:0] r_areg, r_breg, r_dreg;
   logic                    r_out_valid, r_out_last, r_done;
   logic [NUMBANKS-1:0]     r_out_mask;
   logic [ROWW-1:0]         r_arow, r_brow, r_crow;

   logic [LOG2MAXVL:0]      w_vl;
   logic                    w_accept, w_start, w_issue, w_wb_fire;
   logic [LOG2MAXGROUPS-1:0] w_rd_grp, w_wr_grp;
   logic [NUMBANKS-1:0]     w_rd_mask, w_wr_mask;
   logic                    w_rd_last, w_wr_last, w_rd_busy, w_wr_busy;
   logic [ROWW-1:0]         w_arow, w_brow, w_crow;

   assign w_vl      = (in_vl > MAXVL) ? MAXVL : in_vl;
   assign in_ready  = r_state == ST_IDLE;
   assign w_accept  = in_ready & in_valid;
   assign w_start   = w_accept & (w_vl != '0);
   assign w_issue   = (r_state == ST_ACTIVE) & w_rd_busy & (!r_out_valid | out_ready);
   assign wb_ready  = (r_state != ST_IDLE) & w_wr_busy;
   assign w_wb_fire = wb_valid & wb_ready;

   vregfile_grp_ctr #(.NUMBANKS(NUMBANKS), .LOG2NUMBANKS(LOG2NUMBANKS), .LOG2MAXGROUPS(LOG2MAXGROUPS)) u_rd_ctr (
      .i_clk(clk), .i_rst_n(resetn), .i_load(w_start), .i_vl(w_vl), .i_advance(w_issue),
      .o_grp(w_rd_grp), .o_mask(w_rd_mask), .o_last(w_rd_last), .o_busy(w_rd_busy));

   vregfile_grp_ctr #(.NUMBANKS(NUMBANKS), .LOG2NUMBANKS(LOG2NUMBANKS), .LOG2MAXGROUPS(LOG2MAXGROUPS)) u_wr_ctr (
      .i_clk(clk), .i_rst_n(resetn), .i_load(w_start), .i_vl(w_vl), .i_advance(w_wb_fire),
      .o_grp(w_wr_grp), .o_mask(w_wr_mask), .o_last(w_wr_last), .o_busy(w_wr_busy));

   assign w_arow = ROWW'(row_addr(32'(r_areg), 32'(w_rd_grp), LOG2MAXGROUPS));
   assign w_brow = ROWW'(row_addr(32'(r_breg), 32'(w_rd_grp), LOG2MAXGROUPS));
   assign w_crow = ROWW'(row_addr(32'(r_dreg), 32'(w_wr_grp), LOG2MAXGROUPS));

   // Addresses hold their last issued row whenever nothing is issued, so a stalled RAM keeps q_b.
   assign a_reg = {NUMBANKS{w_issue ? w_arow : r_arow}};
   assign b_reg = {NUMBANKS{w_issue ? w_brow : r_brow}};
   assign c_reg = {NUMBANKS{w_wb_fire ? w_crow : r_crow}};

   always_comb begin
      a_en     = w_issue ? w_rd_mask : '0;
      b_en     = w_issue ? w_rd_mask : '0;
      c_we     = w_wb_fire ? w_wr_mask : '0;
      c_byteen = '0;
      for (int k = 0; k < NUMBANKS; k++)
         for (int by = 0; by < BPE; by++)
            c_byteen[k*BPE+by] = w_wb_fire & w_wr_mask[k] & wb_byteen[k*BPE+by];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_areg      <= '0;
         r_breg      <= '0;
         r_dreg      <= '0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_mask  <= '0;
         r_out_last  <= 1'b0;
         r_arow      <= '0;
         r_brow      <= '0;
         r_crow      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_areg <= in_areg;
               r_breg <= in_breg;
               r_dreg <= in_dreg;
               if (w_vl == '0) r_done  <= 1'b1;
               else            r_state <= ST_ACTIVE;
            end
            ST_ACTIVE: if (w_wb_fire && w_wr_last) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end else if (w_issue && w_rd_last) begin
               r_state <= ST_WBONLY;
            end
            ST_WBONLY: if (w_wb_fire && w_wr_last) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_mask  <= w_rd_mask;
            r_out_last  <= w_rd_last;
            r_arow      <= w_arow;
            r_brow      <= w_brow;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
         end
         if (w_wb_fire) r_crow <= w_crow;
      end
   end

   assign out_valid = r_out_valid;
   assign out_mask  = r_out_mask;
   assign out_last  = r_out_last;
   assign done      = r_done;

`ifdef VREGFILE_SCHED_PERF_EN
   logic [31:0] r_stall_cycles;
   logic        w_stall;

   assign w_stall = (r_out_valid & !out_ready) | ((r_state != ST_IDLE) & wb_ready & !wb_valid);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                r_stall_cycles <= '0;
      else if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
